// File: rtl/core_pkg.sv
// Shared decode-stage types: RV32I major-opcode encodings (instr[6:2]), the decoded
// bundle stored per skid entry, the buffer state encoding and opcode classification helpers.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int SKID_DEPTH = 2;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef struct packed {
    logic [4:0]      op_code;
    logic [XLEN-1:0] imm_raw;
    logic            sign_extender_en;
    logic            sign_extender_type;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            illegal;
  } dec_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } skid_state_t;

  function automatic logic opc_supported(input logic [4:0] opc);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_LOAD, OPC_STORE,
      OPC_JALR, OPC_JAL, OPC_BRANCH, OPC_OP, OPC_SYSTEM: ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // OP and SYSTEM are legal but carry no immediate for the extender.
  function automatic logic opc_has_imm(input logic [4:0] opc);
    logic has;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_LOAD, OPC_STORE,
      OPC_JALR, OPC_JAL, OPC_BRANCH: has = 1'b1;
      default:                       has = 1'b0;
    endcase
    return has;
  endfunction

endpackage

// File: rtl/instr_imm_decode_stage_if.sv
// Fetch-side valid/ready handshake plus the registered decoded bundle toward the extender.
// slave = the decode stage, master = the surrounding fetch/controller logic.
interface instr_imm_decode_stage_if;
  import core_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] instr;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      op_code;
  logic [XLEN-1:0] imm_raw;
  logic            sign_extender_en;
  logic            sign_extender_type;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            illegal;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, op_code, imm_raw, sign_extender_en, sign_extender_type,
           rd, rs1, rs2, funct3, funct7b5, illegal
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, op_code, imm_raw, sign_extender_en, sign_extender_type,
           rd, rs1, rs2, funct3, funct7b5, illegal
  );

endinterface

// File: rtl/imm_field_decoder.sv
// Combinational RV32I field decoder: raw instruction to the bundle stored in a skid entry.
// Illegal encodings keep their register fields but never drive an immediate or the extender.
module imm_field_decoder
  import core_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output dec_bundle_t     dec_o
);

  logic [4:0] opc_s;
  logic       legal_s;
  logic       sgn_s;

  assign opc_s   = instr_i[6:2];
  assign legal_s = (instr_i[1:0] == 2'b11) && opc_supported(opc_s);
  assign sgn_s   = instr_i[31];

  // Field extraction and per-format immediate assembly.
  always_comb begin
    dec_o          = '0;
    dec_o.op_code  = opc_s;
    dec_o.rd       = instr_i[11:7];
    dec_o.rs1      = instr_i[19:15];
    dec_o.rs2      = instr_i[24:20];
    dec_o.funct3   = instr_i[14:12];
    dec_o.funct7b5 = instr_i[30];
    dec_o.illegal  = !legal_s;
    if (legal_s) begin
      case (opc_s)
        OPC_LUI, OPC_AUIPC:           dec_o.imm_raw = {instr_i[31:12], 12'h000};
        OPC_OPIMM, OPC_LOAD, OPC_JALR: dec_o.imm_raw = {{20{sgn_s}}, instr_i[31:20]};
        OPC_STORE:  dec_o.imm_raw = {{20{sgn_s}}, instr_i[31:25], instr_i[11:7]};
        OPC_JAL:    dec_o.imm_raw = {{12{sgn_s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        OPC_BRANCH: dec_o.imm_raw = {{20{sgn_s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        default:    dec_o.imm_raw = 32'h0000_0000;
      endcase
      dec_o.sign_extender_en   = opc_has_imm(opc_s);
      // Unsigned compare forms: SLTIU, BLTU, BGEU.
      dec_o.sign_extender_type = ((opc_s == OPC_OPIMM) && (instr_i[14:12] == 3'b011)) ||
                                 ((opc_s == OPC_BRANCH) && (instr_i[14:13] == 2'b11));
    end else begin
      dec_o.imm_raw            = 32'h0000_0000;
      dec_o.sign_extender_en   = 1'b0;
      dec_o.sign_extender_type = 1'b0;
    end
  end

endmodule

// File: rtl/instr_imm_decode_stage.sv
// Registered decode stage ahead of the sign extender: decode at accept, 2-entry skid buffer
// (main + skid) so in_ready is a flop with no combinational path from out_ready.
module instr_imm_decode_stage
  import core_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  instr_imm_decode_stage_if.slave   bus
);

  dec_bundle_t dec_s;
  skid_state_t state_q, state_d;
  dec_bundle_t main_q, main_d;
  dec_bundle_t skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        accept_s;
  logic        consume_s;

  imm_field_decoder u_dec (
    .instr_i (bus.instr),
    .dec_o   (dec_s)
  );

  assign accept_s  = bus.in_valid && in_ready_q;
  assign consume_s = out_valid_q && bus.out_ready;

  // Next-state and entry-load logic for the skid buffer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            main_d  = dec_s;
            state_d = FULL1;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL1: begin
          if (accept_s && consume_s) begin
            main_d  = dec_s;
            state_d = FULL1;
          end else if (accept_s) begin
            skid_d  = dec_s;
            state_d = FULL2;
          end else if (consume_s) begin
            state_d = EMPTY;
          end else begin
            state_d = FULL1;
          end
        end
        FULL2: begin
          if (consume_s) begin
            main_d  = skid_q;
            state_d = FULL1;
          end else begin
            state_d = FULL2;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != FULL2);
    out_valid_d = (state_d != EMPTY);
  end

  // State, entries and handshake flags; flush acts as the synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.op_code            = main_q.op_code;
  assign bus.imm_raw            = main_q.imm_raw;
  assign bus.sign_extender_en   = main_q.sign_extender_en;
  assign bus.sign_extender_type = main_q.sign_extender_type;
  assign bus.rd                 = main_q.rd;
  assign bus.rs1                = main_q.rs1;
  assign bus.rs2                = main_q.rs2;
  assign bus.funct3             = main_q.funct3;
  assign bus.funct7b5           = main_q.funct7b5;
  assign bus.illegal            = main_q.illegal;

endmodule

// File: tb/tb_instr_imm_decode_stage.sv
// Directed bench for instr_imm_decode_stage: table of hand-decoded instructions plus
// backpressure, flush and mid-stream reset sequences.
module tb_instr_imm_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  instr_imm_decode_stage_if bus ();

  instr_imm_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  op;
    logic [31:0] imm;
    logic        en;
    logic        typ;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  f3;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] exp_imm [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Load two entries with out_ready low so the buffer ends in FULL2; in_valid stays high with third_i.
  task automatic fill_two(input logic [31:0] a, input logic [31:0] b, input logic [31:0] third_i,
                          input logic keep_valid);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = a;
    @(posedge clk); #1;
    bus.instr     = b;
    @(posedge clk); #1;
    bus.instr     = third_i;
    bus.in_valid  = keep_valid;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 5'b00100, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd1,  5'd0,  3'd0};
    vecs[1]  = '{32'hFE000EE3, 5'b11000, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 5'd29, 5'd0,  3'd0};
    vecs[2]  = '{32'hFE006EE3, 5'b11000, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 5'd29, 5'd0,  3'd6};
    vecs[3]  = '{32'h00000000, 5'b00000, 32'h00000000, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  3'd0};
    vecs[4]  = '{32'h123450B7, 5'b01101, 32'h12345000, 1'b1, 1'b0, 1'b0, 5'd1,  5'd8,  3'd5};
    vecs[5]  = '{32'h0051B113, 5'b00100, 32'h00000005, 1'b1, 1'b1, 1'b0, 5'd2,  5'd3,  3'd3};
    vecs[6]  = '{32'hFE512C23, 5'b01000, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b0, 5'd24, 5'd2,  3'd2};
    vecs[7]  = '{32'h008000EF, 5'b11011, 32'h00000008, 1'b1, 1'b0, 1'b0, 5'd1,  5'd0,  3'd0};
    vecs[8]  = '{32'h002081B3, 5'b01100, 32'h00000000, 1'b0, 1'b0, 1'b0, 5'd3,  5'd1,  3'd0};
    vecs[9]  = '{32'hFFF00091, 5'b00100, 32'h00000000, 1'b0, 1'b0, 1'b1, 5'd1,  5'd0,  3'd0};
    vecs[10] = '{32'h0000000F, 5'b00011, 32'h00000000, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  3'd0};
    vecs[11] = '{32'hFFFFF297, 5'b00101, 32'hFFFFF000, 1'b1, 1'b0, 1'b0, 5'd5,  5'd31, 3'd7};
    vecs[12] = '{32'h01032203, 5'b00000, 32'h00000010, 1'b1, 1'b0, 1'b0, 5'd4,  5'd6,  3'd2};
    vecs[13] = '{32'h00008067, 5'b11001, 32'h00000000, 1'b1, 1'b0, 1'b0, 5'd0,  5'd1,  3'd0};
    vecs[14] = '{32'h00000073, 5'b11100, 32'h00000000, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  3'd0};
    vecs[15] = '{32'hFFDFF06F, 5'b11011, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 5'd0,  5'd31, 3'd7};

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_imm_raw",   bus.imm_raw,            32'd0);
    check("rst_op_code",   {27'd0, bus.op_code},   32'd0);
    check("rst_illegal",   {31'd0, bus.illegal},   32'd0);
    rst_n = 1'b1;

    // Single-instruction decode table with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.instr     = vecs[i].instr;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid},          32'd1);
      check($sformatf("v%0d_op_code", i),   {27'd0, bus.op_code},            {27'd0, vecs[i].op});
      check($sformatf("v%0d_imm_raw", i),   bus.imm_raw,                     vecs[i].imm);
      check($sformatf("v%0d_en", i),        {31'd0, bus.sign_extender_en},   {31'd0, vecs[i].en});
      check($sformatf("v%0d_type", i),      {31'd0, bus.sign_extender_type}, {31'd0, vecs[i].typ});
      check($sformatf("v%0d_illegal", i),   {31'd0, bus.illegal},            {31'd0, vecs[i].ill});
      check($sformatf("v%0d_rd", i),        {27'd0, bus.rd},                 {27'd0, vecs[i].rd});
      check($sformatf("v%0d_rs1", i),       {27'd0, bus.rs1},                {27'd0, vecs[i].rs1});
      check($sformatf("v%0d_funct3", i),    {29'd0, bus.funct3},             {29'd0, vecs[i].f3});
    end
    @(negedge clk);
    check("table_drained", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: third of three back-to-back instructions stalls, then drain in order.
    exp_imm[0] = 32'd1;
    exp_imm[1] = 32'd2;
    exp_imm[2] = 32'd3;
    fill_two(32'h00100093, 32'h00200093, 32'h00300093, 1'b1);
    @(negedge clk);
    check("bp_stall_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp_head_imm",    bus.imm_raw,           32'd1);
    @(negedge clk);
    check("bp_hold_ready",  {31'd0, bus.in_ready}, 32'd0);
    check("bp_hold_imm",    bus.imm_raw,           32'd1);
    bus.out_ready = 1'b1;
    begin
      int  idx;
      logic acc;
      idx = 0;
      for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
        if (cyc > 0) @(negedge clk);
        if (bus.out_valid) begin
          check($sformatf("bp_drain_%0d", idx), bus.imm_raw, exp_imm[idx]);
          idx++;
        end
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        if (acc) bus.in_valid = 1'b0;
      end
      check("bp_drain_count", idx, 32'd3);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_no_duplicate", {31'd0, bus.out_valid}, 32'd0);

    // Flush while FULL2 with a new instruction presented.
    fill_two(32'h00100093, 32'h00200093, 32'h00700093, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_full2_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_full2_ready", {31'd0, bus.in_ready},  32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("flush_not_accepted", {31'd0, bus.out_valid}, 32'd0);

    // Flush beats a simultaneous accept in FULL1.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h00100093;
    @(posedge clk); #1;
    bus.instr     = 32'h00200093;
    flush         = 1'b1;
    @(posedge clk); #1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("flush_prio_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_prio_ready", {31'd0, bus.in_ready},  32'd1);

    // Asynchronous reset mid-stream while FULL2 is held.
    fill_two(32'h00100093, 32'h00200093, 32'h0, 1'b0);
    @(negedge clk);
    check("rst_mid_pre_ready", {31'd0, bus.in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.in_ready},  32'd1);
    check("rst_mid_imm",   bus.imm_raw,            32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_after", {31'd0, bus.out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
